// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU result port, load issue/return ports,
// register-file write port and hazard status outputs.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        issue_stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        rf_write;
  logic [4:0]  rf_daddr;
  logic [31:0] rf_ddata;
  logic [31:0] busy;
  logic        ld_err;

  // Pipeline side: drives ALU results, load issues and load returns.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd, ld_valid, ld_data,
    input  alu_stall, issue_stall,
    input  rf_write, rf_daddr, rf_ddata, busy, ld_err
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd, ld_valid, ld_data,
    output alu_stall, issue_stall,
    output rf_write, rf_daddr, rf_ddata, busy, ld_err
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and in-order load
// returns into the register file's single write port. Loads wait in an
// in-order queue; the ALU has priority, but a queue head that is ready
// and has lost STARVE_MAX cycles in a row wins the next cycle.
module writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic rst,
  writeback_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 2);

  // Load queue storage
  logic [4:0]  q_rd     [DEPTH];
  logic        q_filled [DEPTH];
  logic [31:0] q_data   [DEPTH];

  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0] count, unfilled;
  logic [SW-1:0] starve;
  logic [31:0]   busy_q;
  logic          rf_write_q;
  logic [4:0]    rf_daddr_q;
  logic [31:0]   rf_ddata_q;
  logic          ld_err_q;

  logic          head_rdy, force_head, issue_ok, fill_ok, retire, take_alu;
  logic          keep_busy;
  logic [4:0]    head_rd, sel_rd;
  logic [31:0]   sel_data, busy_next;
  logic [SW-1:0] starve_next;
  logic [CW-1:0] count_next, unfilled_next;

  // Source selection: ALU first, unless the ready head has starved long enough
  always_comb begin
    head_rd    = q_rd[head_ptr];
    head_rdy   = (count != '0) && q_filled[head_ptr];
    force_head = head_rdy && (starve == SW'(STARVE_MAX));
    issue_ok   = bus.ld_issue && (count != CW'(DEPTH));
    fill_ok    = bus.ld_valid && (unfilled != '0);
    retire     = force_head || (head_rdy && !bus.alu_valid);
    take_alu   = bus.alu_valid && !force_head;
    sel_rd     = retire ? head_rd : bus.alu_rd;
    sel_data   = retire ? q_data[head_ptr] : bus.alu_data;
    starve_next = '0;
    if (!force_head && bus.alu_valid && head_rdy)
      starve_next = starve + SW'(1);
    count_next    = count + CW'(issue_ok) - CW'(retire);
    unfilled_next = unfilled + CW'(issue_ok) - CW'(fill_ok);
  end

  // A retiring load leaves its busy bit set if a younger load targets the same register
  always_comb begin
    keep_busy = issue_ok && (bus.ld_rd == head_rd);
    for (int k = 1; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (q_rd[head_ptr + PW'(k)] == head_rd))
        keep_busy = 1'b1;
    end
    busy_next = busy_q;
    if (retire && !keep_busy)
      busy_next[head_rd] = 1'b0;
    if (issue_ok)
      busy_next[bus.ld_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Queue entry writes; allocation and fill never hit the same slot
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      q_rd[alloc_ptr]     <= bus.ld_rd;
      q_filled[alloc_ptr] <= 1'b0;
    end
    if (fill_ok) begin
      q_data[fill_ptr]   <= bus.ld_data;
      q_filled[fill_ptr] <= 1'b1;
    end
  end

  // Queue pointers, counters, scoreboard, error flag and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      head_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      starve     <= '0;
      busy_q     <= '0;
      ld_err_q   <= 1'b0;
      rf_write_q <= 1'b0;
      rf_daddr_q <= '0;
      rf_ddata_q <= '0;
    end else begin
      if (issue_ok)
        alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_ok)
        fill_ptr <= fill_ptr + PW'(1);
      if (retire)
        head_ptr <= head_ptr + PW'(1);
      if (bus.ld_valid && !fill_ok)
        ld_err_q <= 1'b1;
      count      <= count_next;
      unfilled   <= unfilled_next;
      starve     <= starve_next;
      busy_q     <= busy_next;
      rf_write_q <= (retire || take_alu) && (sel_rd != 5'd0);
      if (retire || take_alu) begin
        rf_daddr_q <= sel_rd;
        rf_ddata_q <= sel_data;
      end
    end
  end

  assign bus.alu_stall   = bus.alu_valid && force_head;
  assign bus.issue_stall = (count == CW'(DEPTH));
  assign bus.rf_write    = rf_write_q;
  assign bus.rf_daddr    = rf_daddr_q;
  assign bus.rf_ddata    = rf_ddata_q;
  assign bus.busy        = busy_q;
  assign bus.ld_err      = ld_err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a vector table for the ALU path,
// load latency, queue-full and repeated-destination cases, plus hand
// sequences for starvation and error/reset behaviour.
module tb_writeback_arbiter;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        exp_alu_stall;
    logic        exp_issue_stall;
    logic        exp_write;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_busy;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  writeback_arbiter_if bus ();

  writeback_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adata,
    input logic li, input logic [4:0] lrd,
    input logic lv, input logic [31:0] ldata,
    input logic eas, input logic eis,
    input logic ew, input logic [4:0] ea, input logic [31:0] ed,
    input logic [31:0] eb, input logic ee);
    vec_t v;
    v.alu_valid = av;  v.alu_rd = ard; v.alu_data = adata;
    v.ld_issue = li;   v.ld_rd = lrd;
    v.ld_valid = lv;   v.ld_data = ldata;
    v.exp_alu_stall = eas; v.exp_issue_stall = eis;
    v.exp_write = ew;  v.exp_addr = ea; v.exp_data = ed;
    v.exp_busy = eb;   v.exp_err = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.alu_valid = v.alu_valid;
    bus.alu_rd    = v.alu_rd;
    bus.alu_data  = v.alu_data;
    bus.ld_issue  = v.ld_issue;
    bus.ld_rd     = v.ld_rd;
    bus.ld_valid  = v.ld_valid;
    bus.ld_data   = v.ld_data;
  endtask

  task automatic setIdle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_issue = 1'b0;  bus.ld_rd = '0;
    bus.ld_valid = 1'b0;  bus.ld_data = '0;
  endtask

  // Called one unit after a rising edge: drive, check combinational
  // outputs mid-cycle, then check registered outputs after the next edge.
  task automatic runVector(input string tag, input vec_t v);
    applyStimulus(v);
    #4;
    checkOutput({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(v.exp_alu_stall));
    checkOutput({tag, ".issue_stall"}, 32'(bus.issue_stall), 32'(v.exp_issue_stall));
    @(posedge clk);
    #1;
    checkOutput({tag, ".rf_write"}, 32'(bus.rf_write), 32'(v.exp_write));
    if (v.exp_write) begin
      checkOutput({tag, ".rf_daddr"}, 32'(bus.rf_daddr), 32'(v.exp_addr));
      checkOutput({tag, ".rf_ddata"}, bus.rf_ddata, v.exp_data);
    end
    checkOutput({tag, ".busy"}, bus.busy, v.exp_busy);
    checkOutput({tag, ".ld_err"}, 32'(bus.ld_err), 32'(v.exp_err));
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    #4;
    checkOutput({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'd0);
    checkOutput({tag, ".issue_stall"}, 32'(bus.issue_stall), 32'd0);
    checkOutput({tag, ".rf_write"}, 32'(bus.rf_write), 32'd0);
    checkOutput({tag, ".rf_daddr"}, 32'(bus.rf_daddr), 32'd0);
    checkOutput({tag, ".rf_ddata"}, bus.rf_ddata, 32'd0);
    checkOutput({tag, ".busy"}, bus.busy, 32'd0);
    checkOutput({tag, ".ld_err"}, 32'(bus.ld_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Main test sequence
  initial begin
    checks   = 0;
    failures = 0;
    setIdle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    // ALU writes, x0 suppression
    vecs.push_back(mk(1, 5, 32'h1234, 0, 0, 0, 0,        0, 0, 1, 5, 32'h1234, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h5555, 0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h0, 0));
    // Single load to x7, data returns three cycles after issue
    vecs.push_back(mk(0, 0, 0,        1, 7, 0, 0,        0, 0, 0, 0, 0,        32'h80, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h80, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h80, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'hCAFE, 0, 0, 0, 0, 0,        32'h80, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 1, 7, 32'hCAFE, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h0, 0));
    // Fill the queue with x1..x4, fifth issue ignored, in-order retire
    vecs.push_back(mk(0, 0, 0,        1, 1, 0, 0,        0, 0, 0, 0, 0,        32'h02, 0));
    vecs.push_back(mk(0, 0, 0,        1, 2, 0, 0,        0, 0, 0, 0, 0,        32'h06, 0));
    vecs.push_back(mk(0, 0, 0,        1, 3, 0, 0,        0, 0, 0, 0, 0,        32'h0E, 0));
    vecs.push_back(mk(0, 0, 0,        1, 4, 0, 0,        0, 0, 0, 0, 0,        32'h1E, 0));
    vecs.push_back(mk(0, 0, 0,        1, 5, 0, 0,        0, 1, 0, 0, 0,        32'h1E, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h11,   0, 1, 0, 0, 0,        32'h1E, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h22,   0, 1, 1, 1, 32'h11,   32'h1C, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h33,   0, 0, 1, 2, 32'h22,   32'h18, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h44,   0, 0, 1, 3, 32'h33,   32'h10, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 1, 4, 32'h44,   32'h0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 0, 0, 0,        32'h0, 0));
    // Two loads to x9: busy survives the first retire
    vecs.push_back(mk(0, 0, 0,        1, 9, 0, 0,        0, 0, 0, 0, 0,        32'h200, 0));
    vecs.push_back(mk(0, 0, 0,        1, 9, 1, 32'h91,   0, 0, 0, 0, 0,        32'h200, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 1, 9, 32'h91,   32'h200, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h92,   0, 0, 0, 0, 0,        32'h200, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 1, 9, 32'h92,   32'h0, 0));
    // Issue to x3 on the same edge that x3 retires: set wins
    vecs.push_back(mk(0, 0, 0,        1, 3, 0, 0,        0, 0, 0, 0, 0,        32'h08, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h3A,   0, 0, 0, 0, 0,        32'h08, 0));
    vecs.push_back(mk(0, 0, 0,        1, 3, 0, 0,        0, 0, 1, 3, 32'h3A,   32'h08, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 1, 32'h3B,   0, 0, 0, 0, 0,        32'h08, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0, 0,        0, 0, 1, 3, 32'h3B,   32'h0, 0));

    foreach (vecs[i])
      runVector($sformatf("vec%0d", i), vecs[i]);

    // Starvation: filled head loses three times to the ALU, then wins
    runVector("starve_issue", mk(0, 0,  0,     1, 6, 0, 0,      0, 0, 0, 0,  0,     32'h40, 0));
    runVector("starve_fill",  mk(0, 0,  0,     0, 0, 1, 32'h66, 0, 0, 0, 0,  0,     32'h40, 0));
    runVector("starve_alu0",  mk(1, 10, 32'hA0, 0, 0, 0, 0,     0, 0, 1, 10, 32'hA0, 32'h40, 0));
    runVector("starve_alu1",  mk(1, 11, 32'hA1, 0, 0, 0, 0,     0, 0, 1, 11, 32'hA1, 32'h40, 0));
    runVector("starve_alu2",  mk(1, 12, 32'hA2, 0, 0, 0, 0,     0, 0, 1, 12, 32'hA2, 32'h40, 0));
    runVector("starve_force", mk(1, 13, 32'hA3, 0, 0, 0, 0,     1, 0, 1, 6,  32'h66, 32'h0,  0));
    runVector("starve_held",  mk(1, 13, 32'hA3, 0, 0, 0, 0,     0, 0, 1, 13, 32'hA3, 32'h0,  0));
    runVector("starve_idle",  mk(0, 0,  0,     0, 0, 0, 0,      0, 0, 0, 0,  0,     32'h0,  0));

    // Stray return sets sticky error; reset clears it and flushes the queue
    runVector("err_stray",  mk(0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0, 0, 0, 32'h0,   1));
    runVector("err_sticky", mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 32'h0,   1));
    runVector("err_issue",  mk(0, 0, 0, 1, 8, 0, 0,        0, 0, 0, 0, 0, 32'h100, 1));
    doReset();
    checkResetState("midreset");
    runVector("err_inflight", mk(0, 0, 0, 0, 0, 1, 32'hBEEF, 0, 0, 0, 0, 0, 32'h0, 1));
    runVector("alu_after",    mk(1, 2, 32'h77, 0, 0, 0, 0,   0, 0, 1, 2, 32'h77, 32'h0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
